// File: rtl/at93c46d_responder_pkg.sv
// Shared constants and FSM encoding for the AT93C46D x16 Microwire responder.
package at93c46d_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int WORDS  = 64;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    // Sub-codes carried in A5:A4 when the opcode is OP_EXT
    localparam logic [1:0] EWEN = 2'b11;
    localparam logic [1:0] EWDS = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_READ,
        ST_WDATA,
        ST_WAIT_CS,
        ST_BUSY
    } state_t;

endpackage

// File: rtl/at93c46d_responder_if.sv
// Microwire serial link between the EEPROM initiator and this responder.
interface at93c46d_responder_if;
    logic cs;
    logic sclk;
    logic din;
    logic dout;

    modport master (output cs, output sclk, output din, input dout);
    modport slave  (input cs, input sclk, input din, output dout);
endinterface

// File: rtl/at93c46d_responder_mem.sv
// 64x16 word array: one write port, a registered serial read port and a registered debug read port.
module at93c46d_mem
    import at93c46d_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    // Erased EEPROM contents at configuration time; rst never touches the array
    logic [DATA_W-1:0] mem [WORDS] = '{default: '1};

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        rdata_a <= mem[raddr_a];
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_b <= '0;
        else     rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/at93c46d_responder.sv
// AT93C46D (x16) EEPROM emulator: oversamples the Microwire link and decodes READ/WRITE/ERASE/EWEN/EWDS.
module at93c46d_responder
    import at93c46d_pkg::*;
#(
    parameter int BUSY_CYCLES   = 1000,
    parameter bit WREN_AT_RESET = 1'b1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    at93c46d_responder_if.slave link,
    output logic              busy,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_CYCLES - 1);

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
    logic sclk_prev, cs_s, sclk_s, din_s, rise;
    state_t state_q, state_d;
    logic [3:0] bit_cnt;
    logic [CNT_W-1:0] busy_cnt;
    logic pend_q, wren_q, dout_q, dout_d, commit;
    logic [6:0] cmd_sr;
    logic [7:0] cmd_full;
    logic [1:0] cmd_op, cmd_sub;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= SYNC_STAGES'({cs_sync, link.cs});
            sclk_sync <= SYNC_STAGES'({sclk_sync, link.sclk});
            din_sync  <= SYNC_STAGES'({din_sync, link.din});
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_prev;
    assign cmd_full = {cmd_sr, din_s};
    assign cmd_op   = cmd_full[7:6];
    assign cmd_sub  = cmd_full[5:4];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cs_s && rise && din_s) state_d = ST_CMD;
            ST_CMD: begin
                if (!cs_s) state_d = ST_IDLE;
                else if (rise && bit_cnt == 4'd7) begin
                    case (cmd_op)
                        OP_READ:  state_d = ST_READ;
                        OP_WRITE: state_d = ST_WDATA;
                        default:  state_d = ST_WAIT_CS;
                    endcase
                end
            end
            ST_READ:    if (!cs_s) state_d = ST_IDLE;
            ST_WDATA: begin
                if (!cs_s) state_d = ST_IDLE;
                else if (rise && bit_cnt == 4'd15) state_d = ST_WAIT_CS;
            end
            ST_WAIT_CS: if (!cs_s) state_d = commit ? ST_BUSY : ST_IDLE;
            ST_BUSY:    if (busy_cnt == BUSY_LAST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // dout shows ready/busy status when idle or programming, data bits in READ
    always_comb begin
        dout_d = 1'b0;
        commit = (state_q == ST_WAIT_CS) && !cs_s && pend_q && wren_q;
        if (cs_s) begin
            case (state_q)
                ST_IDLE: dout_d = 1'b1;
                ST_READ: dout_d = rise ? rd_word[~bit_cnt] : dout_q;
                default: dout_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            busy_cnt <= '0;
            pend_q   <= 1'b0;
            wren_q   <= WREN_AT_RESET;
        end else begin
            busy_cnt <= (state_q == ST_BUSY) ? busy_cnt + CNT_W'(1) : '0;
            case (state_q)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    pend_q  <= 1'b0;
                end
                ST_CMD: if (rise) begin
                    bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        pend_q <= (cmd_op == OP_ERASE);
                        if (cmd_op == OP_EXT && cmd_sub == EWEN) wren_q <= 1'b1;
                        if (cmd_op == OP_EXT && cmd_sub == EWDS) wren_q <= 1'b0;
                    end
                end
                ST_READ:  if (rise) bit_cnt <= bit_cnt + 4'd1;
                ST_WDATA: if (rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) pend_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; the FSM decides when they are meaningful
    always_ff @(posedge clk) begin
        if (rise) cmd_sr <= cmd_full[6:0];
        if (state_q == ST_CMD && rise && bit_cnt == 4'd7) begin
            addr_q <= cmd_full[5:0];
            data_q <= '1;
        end
        if (state_q == ST_WDATA && rise) data_q <= {data_q[DATA_W-2:0], din_s};
        if (state_q == ST_READ && rise && bit_cnt == 4'd15) addr_q <= addr_q + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            dout_q    <= dout_d;
            busy      <= (state_d == ST_BUSY);
            wr_strobe <= commit;
            if (commit) begin
                wr_addr <= addr_q;
                wr_data <= data_q;
            end
        end
    end

    assign link.dout = dout_q;

    at93c46d_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .waddr   (addr_q),
        .wdata   (data_q),
        .raddr_a (addr_q),
        .rdata_a (rd_word),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_data)
    );

endmodule

// File: tb/tb_at93c46d_responder.sv
// Directed bench for the AT93C46D responder: drives Microwire frames and checks memory, strobes and dout.
module tb_at93c46d_responder;
    import at93c46d_pkg::*;

    localparam int HALF = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy, wr_strobe;
    logic [5:0]  wr_addr, dbg_addr;
    logic [15:0] wr_data, dbg_data;
    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int busy_cyc = 0;

    at93c46d_responder_if link();

    at93c46d_responder #(
        .BUSY_CYCLES   (1000),
        .WREN_AT_RESET (1'b1),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (busy)      busy_cyc   <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sbit(input logic b, output logic s);
        link.din = b;
        wait_clk(HALF);
        link.sclk = 1'b1;
        wait_clk(HALF);
        s = link.dout;
        link.sclk = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] addr, output logic last);
        logic s;
        link.cs = 1'b1;
        wait_clk(8);
        sbit(1'b1, s);
        sbit(op[1], s);
        sbit(op[0], s);
        for (int i = 5; i >= 0; i--) sbit(addr[i], s);
        last = s;
    endtask

    task automatic end_frame();
        link.din = 1'b0;
        wait_clk(HALF);
        link.cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [15:0] data);
        logic s;
        send_cmd(OP_WRITE, addr, s);
        for (int i = 15; i >= 0; i--) sbit(data[i], s);
        end_frame();
    endtask

    task automatic read_seq(input logic [5:0] addr, input int nbits,
                            output logic dummy, output logic [31:0] val);
        logic s;
        send_cmd(OP_READ, addr, dummy);
        val = '0;
        for (int i = 0; i < nbits; i++) begin
            sbit(1'b0, s);
            val = {val[30:0], s};
        end
        end_frame();
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            wait_clk(1);
            n++;
        end
        check("busy_release", 32'(busy), 32'd0);
    endtask

    task automatic dbg_read(input logic [5:0] addr, output logic [15:0] val);
        dbg_addr = addr;
        wait_clk(2);
        val = dbg_data;
    endtask

    initial begin
        int s0, b0;
        logic dummy, s;
        logic [31:0] val;
        logic [15:0] dv;

        rst = 1'b1;
        link.cs = 1'b0;
        link.sclk = 1'b0;
        link.din = 1'b0;
        dbg_addr = 6'h00;
        wait_clk(5);
        check("rst_dout", 32'(link.dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_dbg_data", 32'(dbg_data), 32'd0);
        rst = 1'b0;
        dbg_read(6'h00, dv);
        check("powerup_ffff", 32'(dv), 32'hFFFF);

        // WRITE 0x05 <= 0xA5C3
        s0 = strobe_cnt;
        b0 = busy_cyc;
        do_write(6'h05, 16'hA5C3);
        wait_not_busy();
        check("write_strobe_count", 32'(strobe_cnt - s0), 32'd1);
        check("write_wr_addr", 32'(wr_addr), 32'h05);
        check("write_wr_data", 32'(wr_data), 32'hA5C3);
        check("write_busy_cycles", 32'(busy_cyc - b0), 32'd1000);
        dbg_read(6'h05, dv);
        check("write_dbg", 32'(dv), 32'hA5C3);

        // READ back 0x05
        read_seq(6'h05, 16, dummy, val);
        check("read_dummy", 32'(dummy), 32'd0);
        check("read_05", val, 32'h0000A5C3);

        // Sequential read wraps 0x3F -> 0x00
        do_write(6'h3F, 16'h1111);
        wait_not_busy();
        do_write(6'h00, 16'h2222);
        wait_not_busy();
        read_seq(6'h3F, 32, dummy, val);
        check("wrap_dummy", 32'(dummy), 32'd0);
        check("read_wrap", val, 32'h11112222);

        // EWDS blocks the write; EWEN + ERASE restores 0xFFFF
        send_cmd(OP_EXT, 6'h00, s);
        end_frame();
        s0 = strobe_cnt;
        do_write(6'h05, 16'h0000);
        wait_clk(20);
        check("ewds_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("ewds_no_busy", 32'(busy), 32'd0);
        dbg_read(6'h05, dv);
        check("ewds_mem_kept", 32'(dv), 32'hA5C3);
        send_cmd(OP_EXT, 6'h30, s);
        end_frame();
        send_cmd(OP_ERASE, 6'h05, s);
        end_frame();
        wait_not_busy();
        check("erase_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("erase_wr_data", 32'(wr_data), 32'hFFFF);
        dbg_read(6'h05, dv);
        check("erase_mem", 32'(dv), 32'hFFFF);

        // Partial WRITE aborted after 10 data bits
        s0 = strobe_cnt;
        send_cmd(OP_WRITE, 6'h3F, s);
        for (int i = 0; i < 10; i++) sbit(1'b0, s);
        link.cs = 1'b0;
        wait_clk(HALF);
        check("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("abort_no_busy", 32'(busy), 32'd0);
        dbg_read(6'h3F, dv);
        check("abort_mem_kept", 32'(dv), 32'h1111);
        read_seq(6'h3F, 16, dummy, val);
        check("abort_read_after", val, 32'h00001111);

        // Status on dout while programming, then ready
        do_write(6'h10, 16'hBEEF);
        link.cs = 1'b1;
        wait_clk(8);
        check("busy_dout_low", 32'(link.dout), 32'd0);
        check("busy_high", 32'(busy), 32'd1);
        wait_not_busy();
        wait_clk(4);
        check("ready_dout_high", 32'(link.dout), 32'd1);
        link.cs = 1'b0;
        wait_clk(8);
        check("cs_low_dout", 32'(link.dout), 32'd0);

        // rst in the middle of a READ
        send_cmd(OP_READ, 6'h10, s);
        for (int i = 0; i < 5; i++) sbit(1'b0, s);
        rst = 1'b1;
        wait_clk(3);
        check("midread_rst_dout", 32'(link.dout), 32'd0);
        link.cs = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        dbg_read(6'h10, dv);
        check("midread_mem_intact", 32'(dv), 32'hBEEF);
        link.cs = 1'b1;
        wait_clk(8);
        check("post_rst_idle_ready", 32'(link.dout), 32'd1);
        link.cs = 1'b0;
        wait_clk(8);
        read_seq(6'h10, 16, dummy, val);
        check("post_rst_read", val, 32'h0000BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
